// File: rtl/pool2x2_stream_if.sv
// Valid/ready stream bundle carrying one signed word per handshake.
// master drives valid/data, slave drives ready.
interface pool2x2_stream_if #(
    parameter int W = 22
) ();
    logic                valid;
    logic                ready;
    logic signed [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pool2x2_stream.sv
// 2x2/stride-2 max/average pooling over a raster-order stream.
// Define POOL_RELU_EN to clamp negative results to zero before the output register.
module pool2x2_stream #(
    parameter int DATA_W     = 22,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_abort,
    input  logic           i_mode,
    pool2x2_stream_if.slave  i_px,
    pool2x2_stream_if.master o_res,
    output logic           o_busy,
    output logic           o_done
);
    if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
        $error("IMG_WIDTH must be even and >= 2");
    end
    if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
        $error("IMG_HEIGHT must be even and >= 2");
    end

    localparam int XW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int SW = DATA_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [XW-1:0]            r_x;
    logic [YW-1:0]            r_y;
    logic                     r_mode;
    logic signed [DATA_W-1:0] r_line [IMG_WIDTH];
    logic signed [DATA_W-1:0] r_col;
    logic signed [DATA_W-1:0] r_res;
    logic                     r_ov;

    logic                     w_in_ready;
    logic                     w_acc;
    logic                     w_abort;
    logic                     w_last_x;
    logic                     w_last_y;
    logic                     w_win;
    logic [XW-1:0]            w_tl_idx;
    logic signed [DATA_W-1:0] w_tl, w_tr, w_bl, w_br;
    logic signed [DATA_W-1:0] w_m0, w_m1, w_max;
    logic signed [SW-1:0]     w_sum;
    logic signed [DATA_W-1:0] w_avg;
    logic signed [DATA_W-1:0] w_pick;
    logic signed [DATA_W-1:0] w_res;
    logic                     w_unused;

    assign w_in_ready = (r_state == S_RUN) && (!r_ov || o_res.ready);
    assign w_acc      = i_px.valid && w_in_ready;
    assign w_abort    = i_abort && (r_state != S_IDLE);
    assign w_last_x   = (r_x == XW'(IMG_WIDTH - 1));
    assign w_last_y   = (r_y == YW'(IMG_HEIGHT - 1));
    assign w_win      = w_acc && r_x[0] && r_y[0];

    // Window sources: top row from the line buffer, bottom-left from the column register.
    assign w_tl_idx = r_x - XW'(1);
    assign w_tl     = r_line[w_tl_idx];
    assign w_tr     = r_line[r_x];
    assign w_bl     = r_col;
    assign w_br     = i_px.data;

    assign w_m0  = (w_tl > w_tr) ? w_tl : w_tr;
    assign w_m1  = (w_bl > w_br) ? w_bl : w_br;
    assign w_max = (w_m0 > w_m1) ? w_m0 : w_m1;

    assign w_sum = {{2{w_tl[DATA_W-1]}}, w_tl} + {{2{w_tr[DATA_W-1]}}, w_tr}
                 + {{2{w_bl[DATA_W-1]}}, w_bl} + {{2{w_br[DATA_W-1]}}, w_br};
    // Bits [SW-1:2] are sum >>> 2; the result always fits back in DATA_W.
    assign w_avg    = w_sum[SW-1:2];
    assign w_unused = &{1'b0, w_sum[1:0]};

    assign w_pick = r_mode ? w_avg : w_max;

`ifdef POOL_RELU_EN
    assign w_res = w_pick[DATA_W-1] ? '0 : w_pick;
`else
    assign w_res = w_pick;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start && !i_abort) w_next = S_RUN;
            S_RUN:   if (i_abort) w_next = S_IDLE;
                     else if (w_acc && w_last_x && w_last_y) w_next = S_DRAIN;
            S_DRAIN: if (i_abort) w_next = S_IDLE;
                     else if (!r_ov || o_res.ready) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start && !i_abort)
                r_mode <= i_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_acc) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMG_WIDTH; i++)
                r_line[i] <= '0;
            r_col <= '0;
        end else if (w_acc) begin
            if (!r_y[0])
                r_line[r_x] <= i_px.data;
            else if (!r_x[0])
                r_col <= i_px.data;
        end
    end

    // A new result may load on the same edge the previous one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov  <= 1'b0;
            r_res <= '0;
        end else if (w_abort) begin
            r_ov <= 1'b0;
        end else if (w_win) begin
            r_ov  <= 1'b1;
            r_res <= w_res;
        end else if (o_res.ready) begin
            r_ov <= 1'b0;
        end
    end

    assign i_px.ready  = w_in_ready;
    assign o_res.valid = r_ov;
    assign o_res.data  = r_res;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream on a 4x4 frame with a frame-level reference model.
// Compare process checks every output handshake, result hold under stall and in_ready gating.
module tb_pool2x2_stream;
    localparam int DW = 22;
    localparam int W  = 4;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic mode = 1'b0;
    logic busy, done;

    pool2x2_stream_if #(.W(DW)) px_if ();
    pool2x2_stream_if #(.W(DW)) res_if ();

    pool2x2_stream #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_mode(mode),
        .i_px(px_if.slave), .o_res(res_if.master), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: whole-frame array, window evaluated from its four pixels.
    int  fr [H][W];
    int  m_n = 0;
    bit  m_mode = 0;
    int  mq[$];
    int  got[$];
    int  done_cnt = 0;
    bit  prev_pend = 0;
    int  prev_val = 0;

    function automatic int pool_ref(bit md, int a, int b, int c, int d);
        int r;
        if (md) r = (a + b + c + d) >>> 2;
        else begin
            r = a;
            if (b > r) r = b;
            if (c > r) r = c;
            if (d > r) r = d;
        end
`ifdef POOL_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_n = 0;
            prev_pend = 0;
        end else begin
            if (prev_pend) begin
                chk(res_if.valid == 1'b1, "hold_valid", int'(res_if.valid), 1);
                chk(int'(res_if.data) == prev_val, "hold_data", int'(res_if.data), prev_val);
            end
            if (done) begin
                done_cnt++;
                chk(mq.size() == 0 && !res_if.valid, "done_after_drain", mq.size(), 0);
            end
            if (px_if.ready && (!busy || (res_if.valid && !res_if.ready)))
                chk(1'b0, "in_ready_gate", 1, 0);
            if (res_if.valid && res_if.ready) begin
                got.push_back(int'(res_if.data));
                if (mq.size() == 0) chk(1'b0, "unexpected_out", int'(res_if.data), 0);
                else begin
                    int e;
                    e = mq.pop_front();
                    chk(int'(res_if.data) == e, "result", int'(res_if.data), e);
                end
            end
            prev_pend = res_if.valid && !res_if.ready && !(busy && abort);
            prev_val  = int'(res_if.data);
            if (!busy && start && !abort) begin
                m_mode = mode;
                m_n = 0;
            end else if (busy && abort) begin
                m_n = 0;
                mq.delete();
            end else if (px_if.valid && px_if.ready) begin
                int x, y, v;
                x = m_n % W;
                y = m_n / W;
                v = int'(px_if.data);
                fr[y][x] = v;
                if ((x % 2) == 1 && (y % 2) == 1)
                    mq.push_back(pool_ref(m_mode, fr[y-1][x-1], fr[y-1][x], fr[y][x-1], v));
                m_n = (m_n + 1) % (W * H);
            end
        end
    end

    // Output-side stall generator: when enabled, each result waits 5 cycles.
    bit stall_en = 0;
    int wait_c = 0;
    initial begin
        res_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_en) res_if.ready = 1'b1;
            else if (res_if.valid) begin
                if (wait_c < 5) begin
                    res_if.ready = 1'b0;
                    wait_c++;
                end else begin
                    res_if.ready = 1'b1;
                    wait_c = 0;
                end
            end else res_if.ready = 1'b0;
        end
    end

    task automatic do_start(input bit m);
        @(posedge clk); #1;
        start = 1'b1;
        mode = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int px[16], input int cnt, input bit poke_start);
        for (int i = 0; i < cnt; i++) begin
            int t;
            px_if.valid = 1'b1;
            px_if.data = DW'(px[i]);
            if (poke_start && i == 7) begin
                start = 1'b1;
                mode = ~m_mode;
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!px_if.ready && t < 100);
            if (t >= 100) chk(1'b0, "accept_timeout", i, cnt);
            @(posedge clk); #1;
            start = 1'b0;
        end
        px_if.valid = 1'b0;
    endtask

    task automatic run_frame(input bit m, input int px[16], input bit stl,
                             input bit poke, input int exp[4]);
        int t;
        got.delete();
        done_cnt = 0;
        stall_en = stl;
        do_start(m);
        feed(px, 16, poke);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 300);
        if (t >= 300) chk(1'b0, "done_timeout", t, 300);
        @(posedge clk); #1;
        @(negedge clk);
        chk(busy == 1'b0, "idle_after_done", int'(busy), 0);
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        chk(got.size() == 4, "out_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size())
                chk(got[i] == exp[i], "literal", got[i], exp[i]);
        stall_en = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
        chk(done == 1'b0, {tag, "_done"}, int'(done), 0);
        chk(res_if.valid == 1'b0, {tag, "_out_valid"}, int'(res_if.valid), 0);
        chk(px_if.ready == 1'b0, {tag, "_in_ready"}, int'(px_if.ready), 0);
        chk(res_if.data == '0, {tag, "_result"}, int'(res_if.data), 0);
    endtask

    int ramp[16];
    int avgp[16];
    int neg8[16];
    int e_max[4];
    int e_avg[4];
    int e_neg[4];

    initial begin
        px_if.valid = 1'b0;
        px_if.data = '0;
        for (int i = 0; i < 16; i++) begin
            ramp[i] = i;
            neg8[i] = -8;
            avgp[i] = -1;
        end
        avgp[0] = -4; avgp[1] = -4; avgp[2] = 8; avgp[3] = 8;
        avgp[4] = -4; avgp[5] = -3; avgp[6] = 8; avgp[7] = 9;
        e_max = '{5, 7, 13, 15};
        e_avg = '{-4, 8, -1, -1};
`ifdef POOL_RELU_EN
        e_neg = '{0, 0, 0, 0};
        e_avg = '{0, 8, 0, 0};
`else
        e_neg = '{-8, -8, -8, -8};
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        run_frame(1'b0, ramp, 1'b0, 1'b0, e_max);
        run_frame(1'b1, avgp, 1'b0, 1'b0, e_avg);
        run_frame(1'b0, ramp, 1'b1, 1'b1, e_max);

        got.delete();
        done_cnt = 0;
        do_start(1'b0);
        feed(ramp, 6, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk(busy == 1'b0, "abort_idle", int'(busy), 0);
        chk(res_if.valid == 1'b0, "abort_out_valid", int'(res_if.valid), 0);
        repeat (3) @(negedge clk);
        chk(done_cnt == 0, "abort_no_done", done_cnt, 0);
        run_frame(1'b0, ramp, 1'b0, 1'b0, e_max);

        do_start(1'b0);
        feed(ramp, 6, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame(1'b1, neg8, 1'b0, 1'b0, e_neg);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
